// File: rtl/mean_stats_pkg.sv
// Shared formats, width helpers and arithmetic helpers for the mean/variance statistics block.
package mean_stats_pkg;

  localparam int unsigned Q_IN_FRAC  = 8;
  localparam int unsigned Q_OUT_FRAC = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic int unsigned sum_w(input int unsigned lanes, input int unsigned beats);
    return 16 + clog2(lanes * beats);
  endfunction

  function automatic int unsigned sq_w(input int unsigned lanes, input int unsigned beats);
    return 32 + clog2(lanes * beats);
  endfunction

  // Q8.8 x Q8.8 -> Q16.16; never exceeds 2^30, so the result is also valid as unsigned.
  function automatic logic [31:0] square16(input logic signed [15:0] x);
    logic signed [31:0] xe;
    xe = x;
    return xe * xe;
  endfunction

endpackage

// File: rtl/mean_stats_tree.sv
// Registered pairwise adder tree with a matching valid pipe; each level widens by one bit.
module mean_stats_tree
  import mean_stats_pkg::*;
#(
  parameter int unsigned LANES  = 64,
  parameter int unsigned IN_W   = 16,
  parameter bit          SIGNED = 1'b1,
  localparam int unsigned Levels = clog2(LANES),
  localparam int unsigned OutW   = IN_W + Levels
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic [LANES*IN_W-1:0] data_i,
  output logic                  valid_o,
  output logic [OutW-1:0]       sum_o
);

  logic [Levels-1:0] vld_q;

  for (genvar l = 1; l <= Levels; l++) begin : g_lvl
    localparam int unsigned Nodes = LANES >> l;
    localparam int unsigned W     = IN_W + l;

    logic [2*Nodes*(W-1)-1:0] src;
    logic [Nodes*W-1:0]       sum_d;
    logic [Nodes*W-1:0]       sum_q;

    if (l == 1) begin : g_first
      assign src = data_i;
    end else begin : g_next
      assign src = g_lvl[l-1].sum_q;
    end

    always_comb begin
      sum_d = '0;
      for (int n = 0; n < Nodes; n++) begin
        sum_d[n*W +: W] = {SIGNED & src[(2*n+1)*(W-1)-1], src[2*n*(W-1) +: W-1]}
                        + {SIGNED & src[(2*n+2)*(W-1)-1], src[(2*n+1)*(W-1) +: W-1]};
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sum_q <= '0;
      end else if (en_i) begin
        sum_q <= sum_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= valid_i;
      for (int k = 1; k < Levels; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign valid_o = vld_q[Levels-1];
  assign sum_o   = g_lvl[Levels].sum_q;

endmodule

// File: rtl/mean_var_stats.sv
// Streaming per-row mean, E[x^2], mean^2 and variance of signed Q8.8 rows.
// Define MEAN_VAR_STATS_ROUND_EN to round mean and E[x^2] half-up instead of flooring.
module mean_var_stats
  import mean_stats_pkg::*;
#(
  parameter int unsigned LANES  = 64,
  parameter int unsigned BEATS  = 1,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_in,
  output logic [15:0]             mean,
  output logic [31:0]             mean_x2,
  output logic [31:0]             mean_sq,
  output logic [31:0]             variance,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned SqW    = 2 * DATA_W;
  localparam int unsigned Lvl    = clog2(LANES);
  localparam int unsigned Shift  = clog2(LANES * BEATS);
  localparam int unsigned TreeXW = DATA_W + Lvl;
  localparam int unsigned TreeQW = SqW + Lvl;
  localparam int unsigned SumW   = sum_w(LANES, BEATS);
  localparam int unsigned SqAccW = sq_w(LANES, BEATS);
  localparam int unsigned CntW   = (BEATS > 1) ? clog2(BEATS) : 1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                    s1_valid_q;
  logic [LANES*DATA_W-1:0] s1_x_q;
  logic [LANES*SqW-1:0]    s1_sq_d, s1_sq_q;

  always_comb begin
    s1_sq_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sq_d[i*SqW +: SqW] = square16(a_in[i*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_sq_q    <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_x_q     <= a_in;
      s1_sq_q    <= s1_sq_d;
    end
  end

  logic              tx_valid, tq_valid, tree_valid;
  logic [TreeXW-1:0] tree_x;
  logic [TreeQW-1:0] tree_q;

  mean_stats_tree #(
    .LANES  (LANES),
    .IN_W   (DATA_W),
    .SIGNED (1'b1)
  ) u_tree_x (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .valid_i (s1_valid_q),
    .data_i  (s1_x_q),
    .valid_o (tx_valid),
    .sum_o   (tree_x)
  );

  mean_stats_tree #(
    .LANES  (LANES),
    .IN_W   (SqW),
    .SIGNED (1'b0)
  ) u_tree_sq (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .valid_i (s1_valid_q),
    .data_i  (s1_sq_q),
    .valid_o (tq_valid),
    .sum_o   (tree_q)
  );

  assign tree_valid = tx_valid && tq_valid;

  logic [CntW-1:0]          beat_cnt_q;
  logic                     last_beat;
  logic signed [SumW-1:0]   x_ext, sum_nxt, acc_sum_q, tot_sum_q;
  logic [SqAccW-1:0]        q_ext, sq_nxt, acc_sq_q, tot_sq_q;
  logic                     tot_valid_q;

  always_comb begin
    x_ext     = SumW'($signed(tree_x));
    q_ext     = SqAccW'(tree_q);
    last_beat = (beat_cnt_q == CntW'(BEATS - 1));
    sum_nxt   = (beat_cnt_q == '0) ? x_ext : acc_sum_q + x_ext;
    sq_nxt    = (beat_cnt_q == '0) ? q_ext : acc_sq_q + q_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      acc_sum_q   <= '0;
      acc_sq_q    <= '0;
      tot_valid_q <= 1'b0;
      tot_sum_q   <= '0;
      tot_sq_q    <= '0;
    end else if (en) begin
      tot_valid_q <= tree_valid && last_beat;
      if (tree_valid) begin
        acc_sum_q  <= sum_nxt;
        acc_sq_q   <= sq_nxt;
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CntW'(1);
        if (last_beat) begin
          tot_sum_q <= sum_nxt;
          tot_sq_q  <= sq_nxt;
        end
      end
    end
  end

  logic signed [SumW-1:0] sum_rnd;
  logic [SqAccW-1:0]      sq_rnd;
  logic [DATA_W-1:0]      mean_d;
  logic [SqW-1:0]         mx2_d, msq_d;

  always_comb begin
`ifdef MEAN_VAR_STATS_ROUND_EN
    // Signed bias on the sum makes exact halves round toward +inf.
    sum_rnd = tot_sum_q + SumW'(1 << (Shift - 1));
    sq_rnd  = tot_sq_q + SqAccW'(1 << (Shift - 1));
`else
    sum_rnd = tot_sum_q;
    sq_rnd  = tot_sq_q;
`endif
    mean_d = DATA_W'(sum_rnd >>> Shift);
    mx2_d  = SqW'(sq_rnd >> Shift);
    msq_d  = square16(mean_d);
  end

  logic              f1_valid_q;
  logic [DATA_W-1:0] f1_mean_q;
  logic [SqW-1:0]    f1_mx2_q, f1_msq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f1_valid_q <= 1'b0;
      f1_mean_q  <= '0;
      f1_mx2_q   <= '0;
      f1_msq_q   <= '0;
    end else if (en) begin
      f1_valid_q <= tot_valid_q;
      f1_mean_q  <= mean_d;
      f1_mx2_q   <= mx2_d;
      f1_msq_q   <= msq_d;
    end
  end

  logic [SqW:0]      var_diff;
  logic [SqW-1:0]    var_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] mean_q;
  logic [SqW-1:0]    mean_x2_q, mean_sq_q, variance_q;

  always_comb begin
    var_diff = {1'b0, f1_mx2_q} - {1'b0, f1_msq_q};
    var_d    = var_diff[SqW] ? '0 : var_diff[SqW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      mean_q      <= '0;
      mean_x2_q   <= '0;
      mean_sq_q   <= '0;
      variance_q  <= '0;
    end else if (en) begin
      out_valid_q <= f1_valid_q;
      if (f1_valid_q) begin
        mean_q     <= f1_mean_q;
        mean_x2_q  <= f1_mx2_q;
        mean_sq_q  <= f1_msq_q;
        variance_q <= var_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign mean      = mean_q;
  assign mean_x2   = mean_x2_q;
  assign mean_sq   = mean_sq_q;
  assign variance  = variance_q;

endmodule

// File: doc/mean_var_stats.md
# mean_var_stats

Parametrised streaming statistics block for layer/row normalisation. Accepts signed Q8.8 rows delivered as one or more beats of `LANES` elements and produces, per row, the mean (Q8.8), the mean of squares E[x²] (Q16.16), the squared mean (Q16.16) and the variance (Q16.16). It sits between the activation buffer and the normalisation scaler, with valid/ready on both sides and full backpressure.

## Interface

- `LANES`, 64: elements per beat; power of two, 2..64.
- `BEATS`, 1: beats per row; power of two, 1..16.
- `DATA_W`, 16: element width, signed Q8.8; fixed at 16.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `a_in` in LANES*16: lane i at `[i*16 +: 16]`, signed Q8.8.
- `mean` out 16: signed Q8.8.
- `mean_x2` out 32: unsigned Q16.16, E[x²].
- `mean_sq` out 32: unsigned Q16.16, mean².
- `variance` out 32: unsigned Q16.16, E[x²] − mean², clamped at 0.
- `out_valid` out 1: result valid; held until `out_ready`.
- `out_ready` in 1: consumer ready.

## Operation

- Global enable `en = !out_valid || out_ready`. All pipeline, accumulator and counter registers advance only when `en` is high. `in_ready = en`.
- S1: register each lane x (sign-extended) and x² (32-bit unsigned), plus valid.
- Tree: log2(LANES) registered levels. The x tree grows 1 bit per level and the x² tree does the same, so no truncation and no wrap occurs.
- Accumulate stage:
  - `beat_cnt` counts valid beats 0..BEATS−1.
  - On beat 0, load the accumulators; on later beats, add to them.
  - On beat BEATS−1, forward the totals to the finalise stage and wrap `beat_cnt` to 0.
  - Accumulator widths are DATA_W+log2(LANES*BEATS) and 32+log2(LANES*BEATS).
- Finalise 1: `mean` = sum >>> log2(LANES*BEATS), an arithmetic shift that floors toward −∞. `mean_x2` = sumsq >> same shift. `mean_sq` = mean × mean (signed 16×16, 32-bit result).
- Finalise 2: variance = mean_x2 − mean_sq; a negative result forces 0. The result is loaded into the output register and `out_valid` is set.
- Output register:
  - Loads only when `en` is high.
  - While `out_valid && !out_ready`, all outputs hold stable and the whole pipeline stalls.
  - On an `out_ready` handshake with no new result arriving, `out_valid` clears.
- Bubbles (beats with `in_valid` low) propagate as invalid and do not advance `beat_cnt`.
- Reset state: `out_valid` = 0; `mean`, `mean_x2`, `mean_sq`, `variance` = 0; `beat_cnt` = 0; all stage valids and accumulators = 0.
- Reset mid-row discards the partial row. The first beat after reset is beat 0.

## Timing

- Latency from acceptance of a row's final beat to `out_valid` high is log2(LANES)+4 cycles with no stall (LANES=64: 10 cycles; LANES=4: 6 cycles).
- Each stall cycle adds exactly one cycle of latency.
- Throughput: one beat per cycle, one result per BEATS accepted beats.
- A result can be consumed and the next result loaded in the same cycle (`out_ready` high keeps `en` high).
- `in_ready` is combinational from `out_valid` and `out_ready` only; it does not depend on `in_valid`.

## Configuration

- `MEAN_VAR_STATS_ROUND_EN` defined: `mean` and `mean_x2` round half-up. The block adds 2^(shift−1) before the shift; for `mean` this is signed, so ties round toward +∞.
- Not defined: plain truncation (floor), as described above.
- Latency is identical in both builds.

## Structure

- Package `mean_stats_pkg` holds:
  - Q8.8 / Q16.16 format constants (`Q_IN_FRAC = 8`, `Q_OUT_FRAC = 16`).
  - Width functions `sum_w(lanes, beats)` and `sq_w(lanes, beats)`.
  - The `clog2` helper.
- Sub-module `mean_stats_tree`:
  - Parametrised by `LANES` and `IN_W`, with an enable input.
  - Implements the registered pairwise adder tree with a valid pipe.
  - Instantiated twice, once for x and once for x².

## Test plan

- LANES=4, BEATS=1, lanes {0x0100,0x0200,0x0300,0x0400} → `mean`=0x0280, `mean_x2`=0x00078000, `mean_sq`=0x00064000, `variance`=0x00014000, 6 cycles after acceptance.
- All lanes 0xFF00 (−1.0) → `mean`=0xFF00, `mean_x2`=0x00010000, `mean_sq`=0x00010000, `variance`=0.
- LANES=4, lanes {0x0002,0,0,0} → `mean`=0x0000 truncated, 0x0001 with `MEAN_VAR_STATS_ROUND_EN`. Lanes {0xFFFF,0,0,0} → `mean`=0xFFFF truncated, 0x0000 with `MEAN_VAR_STATS_ROUND_EN`.
- LANES=4, BEATS=2: beat {0x0100×4} then beat {0x0300×4}, with a 2-cycle bubble between → `mean`=0x0200, `mean_x2`=0x00050000, `variance`=0x00010000, exactly one `out_valid` pulse.
- Back-to-back rows with `out_ready` held low for 5 cycles → `in_ready` low during the hold, outputs stable, every row emitted in order with none lost or duplicated.
- `rst` asserted after 1 of 2 beats → all outputs 0, `out_valid` 0; the next two beats form a complete row with the correct result.
